// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode, command record and dispatcher state types shared by the dispatcher slice
package alu_pkg;
    typedef enum logic [3:0] {
        ADD   = 4'b0001,
        AND   = 4'b0010,
        SUB   = 4'b0011,
        MUL   = 4'b0100,
        SHL   = 4'b0111,
        SPEC1 = 4'b1001,
        SPEC2 = 4'b1010,
        SPEC3 = 4'b1011,
        SPEC4 = 4'b1100
    } alu_op_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        alu_op_e    op;
    } alu_cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} disp_state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO, power-of-two depth with naturally wrapping pointers
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  alu_cmd_t               din_i,
    output alu_cmd_t               dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;

    always_comb count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= push_i ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop_i ? rd_q + AW'(1) : rd_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only entries covered by count are ever read
    always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= din_i;

    assign dout_o  = mem_q[rd_q];
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
endmodule

// File: rtl/alu_cmd_dispatcher.sv
// alu_cmd_dispatcher: buffers ALU commands, issues them one at a time with a start pulse,
// and returns each result (or a timeout) on a valid/ready response port
module alu_cmd_dispatcher
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [3:0]  cmd_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_opcode,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_op,
    output logic        rsp_timeout,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT);

    disp_state_e           state_q;
    alu_cmd_t              cmd_in, head, cmd_q;
    logic [CW-1:0]         cnt_q;
    logic [15:0]           result_q;
    logic [3:0]            rsp_op_q;
    logic                  start_q, valid_q, timeout_q;
    logic                  fifo_full, fifo_empty, pop;
    logic [$clog2(DEPTH):0] fifo_count;

    assign cmd_in    = alu_cmd_t'({cmd_a, cmd_b, cmd_op});
    assign cmd_ready = !fifo_full;
    assign pop       = (state_q == IDLE) && !fifo_empty;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (cmd_valid && cmd_ready),
        .pop_i   (pop),
        .din_i   (cmd_in),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            rsp_op_q  <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (!fifo_empty) begin
                    cmd_q   <= head;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    start_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A completion on the last permitted cycle still counts as a real result
                    if (alu_done || cnt_q == CW'(TIMEOUT - 1)) begin
                        result_q  <= alu_done ? alu_result : '0;
                        timeout_q <= !alu_done;
                        rsp_op_q  <= cmd_q.op;
                        valid_q   <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a       = cmd_q.a;
    assign alu_b       = cmd_q.b;
    assign alu_opcode  = cmd_q.op;
    assign alu_start   = start_q;
    assign rsp_valid   = valid_q;
    assign rsp_result  = result_q;
    assign rsp_op      = rsp_op_q;
    assign rsp_timeout = timeout_q;
    assign busy        = (state_q != IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// tb_alu_cmd_dispatcher: behavioural ALU plus response scoreboard around the dispatcher
module tb_alu_cmd_dispatcher;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_start, alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_op;

    alu_cmd_dispatcher #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  op;
        logic        to;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic [15:0] res;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   errors = 0, checks = 0, cyc = 0;
    int   lat = 2, cd = 0, starts = 0, rsp_seen = 0, overlap = 0;
    bit   hang = 0, pending = 0, spur = 0;
    logic [7:0] la, lb;
    logic [3:0] lop;

    function automatic exp_t mk(input logic [15:0] res, input logic [3:0] op, input logic to);
        exp_t e;
        e.res = res;
        e.op  = op;
        e.to  = to;
        return e;
    endfunction

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'h1:    return 16'(a) + 16'(b);
            4'h2:    return {8'h00, a & b};
            4'h3:    return 16'(a) - 16'(b);
            4'h4:    return 16'(a) * 16'(b);
            4'h7:    return 16'(a) << b[3:0];
            default: return {a, b};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: ALU model and response monitor at the falling edge, return just after the rising edge
    task automatic step();
        @(negedge clk);
        alu_done = 1'b0;
        if (rsp_valid && alu_start) overlap++;
        if (spur) begin
            alu_done   = 1'b1;
            alu_result = 16'hBEEF;
            spur       = 0;
        end else if (alu_start) begin
            starts++;
            if (!hang) begin
                pending = 1;
                cd      = lat;
                la      = alu_a;
                lb      = alu_b;
                lop     = alu_opcode;
            end
        end else if (pending) begin
            cd--;
            if (cd == 0) begin
                pending = 0;
                chk("operands stable", 32'({alu_a, alu_b, alu_opcode}), 32'({la, lb, lop}));
                alu_done   = 1'b1;
                alu_result = alu_fn(la, lb, lop);
            end
        end
        if (rsp_valid && rsp_ready) begin
            exp_t e;
            rsp_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected response: result %0h op %0h", rsp_result, rsp_op);
            end else begin
                e = sb.pop_front();
                chk("rsp_result", 32'(rsp_result), 32'(e.res));
                chk("rsp_op", 32'(rsp_op), 32'(e.op));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                            input logic [15:0] res, input logic to, input bit track);
        bit ok = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cmd_ready) begin
                if (track) sb.push_back(mk(res, op, to));
                ok = 1;
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("push accepted", 32'(ok), 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && (sb.size() != 0 || busy); i++) step();
        chk("drain queue", 32'(sb.size()), 0);
        repeat (2) step();
    endtask

    initial begin
        int   accepted, t0, t1, s0, r0;
        bit   found, low_seen;
        logic [15:0] hr;
        logic [3:0]  ho;

        vecs[0] = '{8'h55, 8'h33, 4'h2, 16'h0011};
        vecs[1] = '{8'h55, 8'h33, 4'h3, 16'h0022};
        vecs[2] = '{8'h55, 8'h33, 4'h4, 16'h10EF};
        vecs[3] = '{8'h55, 8'h03, 4'h7, 16'h02A8};
        vecs[4] = '{8'hFF, 8'h01, 4'h1, 16'h0100};

        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_ready", 32'(cmd_ready), 1);
        chk("reset outputs", 32'({alu_start, rsp_valid, rsp_timeout, busy, alu_a, alu_b, alu_opcode}), 0);
        chk("reset rsp", 32'({rsp_result, rsp_op}), 0);
        reset_n = 1'b1;
        step();
        chk("post-reset idle", 32'({cmd_ready, busy, rsp_valid}), 32'b100);

        // Single ADD with start-pulse latency
        rsp_ready = 1'b1;
        lat       = 3;
        s0        = starts;
        cmd_a = 8'h55; cmd_b = 8'h33; cmd_op = 4'h1; cmd_valid = 1'b1;
        sb.push_back(mk(16'h0088, 4'h1, 1'b0));
        step();
        cmd_valid = 1'b0;
        chk("start after N", 32'(alu_start), 0);
        step();
        chk("start after N+1", 32'(alu_start), 0);
        step();
        chk("start after N+2", 32'(alu_start), 1);
        chk("issued operands", 32'({alu_a, alu_b, alu_opcode}), 32'({8'h55, 8'h33, 4'h1}));
        step();
        chk("start one cycle", 32'(alu_start), 0);
        wait_drain();
        chk("single start count", 32'(starts - s0), 1);

        // Back-to-back table vectors
        lat = 2;
        for (int i = 0; i < 5; i++) push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 1'b0, 1);
        wait_drain();

        // Fill with the response port stalled: DEPTH + 1 commands fit
        rsp_ready = 1'b0;
        accepted  = 0;
        low_seen  = 0;
        cmd_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cmd_a  = 8'(16 + accepted);
            cmd_b  = 8'h03;
            cmd_op = 4'h1;
            if (cmd_ready && accepted < 6) begin
                sb.push_back(mk(alu_fn(cmd_a, cmd_b, 4'h1), 4'h1, 1'b0));
                accepted++;
            end
            step();
            if (accepted == 5 && !low_seen) begin
                low_seen = 1;
                chk("cmd_ready after 5th accept", 32'(cmd_ready), 0);
            end
        end
        cmd_valid = 1'b0;
        chk("accepted while stalled", 32'(accepted), 5);
        chk("held rsp_valid", 32'(rsp_valid), 1);
        hr = rsp_result;
        ho = rsp_op;
        repeat (4) step();
        chk("held rsp stable", 32'({rsp_valid, rsp_result, rsp_op}), 32'({1'b1, hr, ho}));
        chk("held rsp value", 32'(rsp_result), 32'(16'h0013));
        rsp_ready = 1'b1;
        wait_drain();

        // Hung ALU: timeout after TIMEOUT cycles in WAIT
        hang = 1;
        push_cmd(8'h01, 8'h02, 4'h1, 16'h0000, 1'b1, 1);
        found = 0;
        t0    = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (alu_start) begin found = 1; t0 = cyc; end
        end
        chk("timeout start seen", 32'(found), 1);
        found = 0;
        t1    = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (rsp_valid) begin found = 1; t1 = cyc; end
        end
        chk("timeout rsp seen", 32'(found), 1);
        chk("timeout latency", 32'(t1 - t0), 64);
        hang = 0;
        wait_drain();
        push_cmd(8'h09, 8'h04, 4'h3, 16'h0005, 1'b0, 1);
        wait_drain();

        // Done on the last WAIT cycle wins; one cycle later is a timeout and the late done is ignored
        lat = 63;
        push_cmd(8'h07, 8'h06, 4'h4, 16'h002A, 1'b0, 1);
        wait_drain();
        lat = 64;
        r0  = rsp_seen;
        push_cmd(8'h02, 8'h03, 4'h1, 16'h0000, 1'b1, 1);
        wait_drain();
        repeat (3) step();
        chk("late done single rsp", 32'(rsp_seen - r0), 1);
        lat = 2;

        // Spurious done while idle
        r0   = rsp_seen;
        spur = 1;
        repeat (6) step();
        chk("spurious done no rsp", 32'(rsp_seen - r0), 0);
        chk("spurious done idle", 32'({busy, rsp_valid}), 0);

        // Reset during WAIT with two commands queued
        hang = 1;
        for (int i = 0; i < 3; i++) push_cmd(8'(i + 1), 8'h01, 4'h1, 16'h0000, 1'b0, 0);
        repeat (4) step();
        chk("busy before reset", 32'(busy), 1);
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        hang    = 0;
        pending = 0;
        step();
        chk("after reset", 32'({rsp_valid, cmd_ready, busy}), 32'b010);
        s0 = starts;
        r0 = rsp_seen;
        repeat (10) step();
        chk("no start after reset", 32'(starts - s0), 0);
        chk("no rsp after reset", 32'(rsp_seen - r0), 0);
        push_cmd(8'h04, 8'h05, 4'h1, 16'h0009, 1'b0, 1);
        wait_drain();

        chk("start never overlaps rsp_valid", 32'(overlap), 0);
        chk("scoreboard empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_cmd_dispatcher.md
Name: alu_cmd_dispatcher

Overview:
Upstream issue stage for the 8-bit multi-cycle ALU (A/B/opcode/start in, done/result out).
- Buffers incoming ALU commands in a small FIFO.
- Issues one command at a time to the ALU with a single-cycle start pulse, holds operands stable until done, and returns each result on a valid/ready response port.
- Guards against a hung ALU with a timeout counter.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 64, max clk cycles in WAIT before aborting an operation (>=2)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_op  input  4  ALU opcode
alu_a  output  8  operand A to ALU
alu_b  output  8  operand B to ALU
alu_opcode  output  4  opcode to ALU
alu_start  output  1  one-cycle start pulse to ALU
alu_done  input  1  ALU completion pulse
alu_result  input  16  ALU result, valid when alu_done=1
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  16  captured result (0 on timeout)
rsp_op  output  4  opcode of the completed command
rsp_timeout  output  1  response produced by timeout, not by alu_done
busy  output  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (async assert, sync release) clears the following to 0: all outputs, FIFO pointers and count, the timeout counter; FSM goes to IDLE. cmd_ready=1 after reset.
- Command push:
  - A command is pushed on any edge with cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count < DEPTH). It is registered-state based, with no combinational path from rsp_ready or alu_done.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the operand registers (alu_a/alu_b/alu_opcode) and go to ISSUE.
- ISSUE: alu_start=1 for exactly this one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - alu_a/alu_b/alu_opcode stay stable. The counter increments each cycle.
  - If alu_done=1: capture alu_result into rsp_result, set rsp_timeout=0, go to RESP.
  - Else if counter == TIMEOUT-1: set rsp_result=0 and rsp_timeout=1, go to RESP.
  - alu_done wins over timeout in the same cycle.
- RESP:
  - rsp_valid=1 and rsp_op = latched opcode. rsp_* stay stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE with rsp_valid=0 the next cycle.
- Latency:
  - A command pushed at edge N into an empty FIFO with the FSM in IDLE gives alu_start high in the cycle after edge N+2.
  - alu_done sampled at edge M gives rsp_valid high after edge M.
- Total buffering is DEPTH (FIFO) + 1 (in flight). Further pushes are stalled by cmd_ready=0.
- Simultaneous push and pop at the same edge are both performed, and the count is unchanged. Pointers wrap modulo DEPTH.
- alu_done in IDLE, ISSUE or RESP is ignored: no state change, no capture.
- alu_start never asserts while rsp_valid=1. Only one command is in flight.
- Reset mid-operation aborts everything: the in-flight and buffered commands are discarded, and no response is produced.

Decomposition:
- alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e (ADD=4'b0001, AND=4'b0010, SUB=4'b0011, MUL=4'b0100, SHL=4'b0111, SPEC1..SPEC4=4'b1001..4'b1100);
  - typedef struct packed alu_cmd_t {a[7:0], b[7:0], op};
  - typedef enum disp_state_e {IDLE, ISSUE, WAIT, RESP}.
- One sub-module, alu_cmd_fifo: synchronous FIFO of alu_cmd_t, parameter DEPTH, with push/pop/full/empty/count.

Test Plan:
- Single ADD, A=0x55, B=0x33 with the real ALU -> one alu_start pulse; rsp_result=0x0088, rsp_op=0001, rsp_timeout=0.
- Back-to-back AND, SUB, MUL on 0x55/0x33 pushed on consecutive cycles, rsp_ready=1 -> responses in order: 0x0011, 0x0022, 0x10EF. Operands are stable from alu_start to alu_done.
- Push 6 commands with rsp_ready=0 -> exactly 5 accepted; cmd_ready low from the 5th accept; rsp_valid held with a stable result. Release rsp_ready -> remaining commands issue in order.
- ALU model never asserts done, TIMEOUT=64 -> rsp_valid is asserted exactly 64 cycles after the alu_start cycle ends, with rsp_timeout=1 and rsp_result=0x0000. The next command then issues normally.
- alu_done forced on the same cycle as counter==TIMEOUT-1 -> rsp_timeout=0 and the ALU result is captured. A spurious alu_done in IDLE causes no response.
- Assert reset_n=0 during WAIT with 2 commands queued -> after release: no rsp_valid, cmd_ready=1, busy=0, and no alu_start until a new push.
